// File: rtl/constraint_stream_checker.sv
// -----------------------------------------------------------------------------
// constraint_stream_checker
//
// Streaming constraint checker. Each candidate sample (NUM_VARS variables of
// VAR_W bits) is evaluated against NUM_CONS runtime-programmable slots. Each
// result reports whether every slot held, and the lowest failing slot index.
// The two-stage pipeline (S1: per-slot result bits, S2: AND-reduce plus
// priority encode) runs at one sample per cycle and respects output
// backpressure. Pass and sample statistics are kept for the sampler loop.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start / stop        control pulses: IDLE->RUN (clears stats) / RUN->DRAIN
//   cfg_we/idx/data     slot write, honoured only in IDLE
//                       cfg_data = {op[2:0], use_imm, sel_a, sel_b, imm}
//   in_valid/ready/vars sample stream; var k = in_vars[k*VAR_W +: VAR_W]
//   out_valid/ready     result stream
//   out_pass            every slot held
//   out_fail_idx        lowest failing slot, 0 on pass
//   busy / done         state != IDLE / one-cycle pulse in DONE
//   sample_cnt/pass_cnt saturating counts of results handed out
//   hit_vars            first passing sample (hit-stop build only, else 0)
//
// Build option: define CSC_HIT_STOP_EN to carry each sample through the pipe,
// latch the first passing one into hit_vars and end RUN on that hit.
// -----------------------------------------------------------------------------
module constraint_stream_checker #(
    parameter int  NUM_VARS = 8,
    parameter int  VAR_W    = 32,
    parameter int  NUM_CONS = 16,
    parameter int  CNT_W    = 32,
    localparam int IW       = $clog2(NUM_VARS),
    localparam int CW       = $clog2(NUM_CONS),
    localparam int CFG_W    = 4 + 2*IW + VAR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      cfg_we,
    input  logic [CW-1:0]             cfg_idx,
    input  logic [CFG_W-1:0]          cfg_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_VARS*VAR_W-1:0] in_vars,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_pass,
    output logic [CW-1:0]             out_fail_idx,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          sample_cnt,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic [NUM_VARS*VAR_W-1:0] hit_vars
);

    typedef enum logic [2:0] {
        OP_NOP, OP_NZ, OP_EQ, OP_NE, OP_LT, OP_ADD_NZ, OP_AND_NZ, OP_XOR_NZ
    } op_e;

    typedef struct packed {
        op_e              op;
        logic             use_imm;
        logic [IW-1:0]    sel_a;
        logic [IW-1:0]    sel_b;
        logic [VAR_W-1:0] imm;
    } slot_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    // Selectors that name no existing variable read as zero.
    function automatic logic [VAR_W-1:0] pick_var(input logic [NUM_VARS*VAR_W-1:0] vars,
                                                  input logic [IW-1:0] sel);
        pick_var = '0;
        for (int k = 0; k < NUM_VARS; k++)
            if (IW'(k) == sel) pick_var = vars[k*VAR_W +: VAR_W];
    endfunction

    function automatic logic eval_slot(input slot_t s, input logic [NUM_VARS*VAR_W-1:0] vars);
        logic [VAR_W-1:0] a, b, sum;
        a   = pick_var(vars, s.sel_a);
        b   = s.use_imm ? s.imm : pick_var(vars, s.sel_b);
        sum = a + b;  // carry discarded at VAR_W bits
        eval_slot = 1'b1;
        case (s.op)
            OP_NOP:    eval_slot = 1'b1;
            OP_NZ:     eval_slot = (a != '0);
            OP_EQ:     eval_slot = (a == b);
            OP_NE:     eval_slot = (a != b);
            OP_LT:     eval_slot = (a < b);
            OP_ADD_NZ: eval_slot = (sum != '0);
            OP_AND_NZ: eval_slot = ((a & b) != '0);
            OP_XOR_NZ: eval_slot = ((a ^ b) != '0);
            default:   eval_slot = 1'b1;
        endcase
    endfunction

    state_e                state, state_nxt;
    slot_t                 slot_tbl [NUM_CONS];
    logic [NUM_CONS-1:0]   slot_res, s1_res;
    logic                  s1_v, s2_v;
    logic                  s1_pass;
    logic [CW-1:0]         s1_fail_idx;
    logic                  adv1, adv2, out_hs, start_acc, hit;

    assign adv2      = !s2_v || out_ready;
    assign adv1      = !s1_v || adv2;
    assign in_ready  = (state == S_RUN) && adv1;
    assign out_valid = s2_v;
    assign out_hs    = s2_v && out_ready;
    assign start_acc = (state == S_IDLE) && start;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;          // start beats a coincident stop
            S_RUN:   if (stop || hit) state_nxt = S_DRAIN;
            S_DRAIN: if (!s1_v && !s2_v) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Slot table ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is a register file, not a RAM macro, so the async
            // reset returns every slot to NOP.
            for (int i = 0; i < NUM_CONS; i++) slot_tbl[i] <= '0;
        end else if (cfg_we && state == S_IDLE) begin
            for (int i = 0; i < NUM_CONS; i++)
                if (CW'(i) == cfg_idx) slot_tbl[i] <= slot_t'(cfg_data);
        end
    end

    // ---------------- Pipeline ----------------
    always_comb begin
        slot_res = '0;
        for (int i = 0; i < NUM_CONS; i++) slot_res[i] = eval_slot(slot_tbl[i], in_vars);
    end

    always_comb begin
        s1_pass     = &s1_res;
        s1_fail_idx = '0;
        // Walk downward so the lowest failing slot is the one left standing.
        for (int i = NUM_CONS-1; i >= 0; i--)
            if (!s1_res[i]) s1_fail_idx = CW'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v         <= 1'b0;
            s1_res       <= '0;
            s2_v         <= 1'b0;
            out_pass     <= 1'b0;
            out_fail_idx <= '0;
        end else begin
            if (adv1) begin
                s1_v   <= in_valid && in_ready;
                s1_res <= slot_res;
            end
            if (adv2) begin
                s2_v         <= s1_v;
                out_pass     <= s1_pass;
                out_fail_idx <= s1_fail_idx;
            end
        end
    end

    // ---------------- Statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            pass_cnt   <= '0;
        end else if (start_acc) begin
            sample_cnt <= '0;
            pass_cnt   <= '0;
        end else if (out_hs) begin
            if (sample_cnt != '1)            sample_cnt <= sample_cnt + 1'b1;
            if (out_pass && pass_cnt != '1)  pass_cnt   <= pass_cnt + 1'b1;
        end
    end

    // ---------------- Optional hit-stop ----------------
`ifdef CSC_HIT_STOP_EN
    logic [NUM_VARS*VAR_W-1:0] s1_vars, s2_vars, hit_q;

    assign hit      = (state == S_RUN) && out_hs && out_pass;
    assign hit_vars = hit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vars <= '0;
            s2_vars <= '0;
            hit_q   <= '0;
        end else begin
            if (adv1) s1_vars <= in_vars;
            if (adv2) s2_vars <= s1_vars;
            if (start_acc) hit_q <= '0;
            else if (hit)  hit_q <= s2_vars;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_vars = '0;
`endif

endmodule

// File: tb/tb_constraint_stream_checker.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for constraint_stream_checker. A second instance
// with NUM_VARS=6 exercises selectors that point past the last variable.
// -----------------------------------------------------------------------------
module tb_constraint_stream_checker;

    localparam int NV = 8, VW = 32, NC = 16, CNTW = 32;
    localparam int IW = 3, CW = 4, CFGW = 4 + 2*IW + VW;
    localparam int NV6 = 6;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, cfg_we = 1'b0;
    logic [CW-1:0] cfg_idx = '0;
    logic [CFGW-1:0] cfg_data = '0;
    logic in_valid = 1'b0, in_ready;
    logic [NV*VW-1:0] in_vars = '0;
    logic out_valid, out_ready = 1'b1, out_pass;
    logic [CW-1:0] out_fail_idx;
    logic busy, done;
    logic [CNTW-1:0] sample_cnt, pass_cnt;
    logic [NV*VW-1:0] hit_vars;

    logic start6 = 1'b0, stop6 = 1'b0, cfg_we6 = 1'b0;
    logic [CW-1:0] cfg_idx6 = '0;
    logic [CFGW-1:0] cfg_data6 = '0;
    logic in_valid6 = 1'b0, in_ready6;
    logic [NV6*VW-1:0] in_vars6 = '0;
    logic out_valid6, out_pass6;
    logic [CW-1:0] out_fail_idx6;
    logic busy6, done6;
    logic [CNTW-1:0] sample_cnt6, pass_cnt6;
    logic [NV6*VW-1:0] hit_vars6;

    int n_vec = 0, n_err = 0;
    int done_cnt = 0, stall_err = 0;
    logic [4:0] res_q [$];          // {pass, fail_idx}
    logic [4:0] exp_q [$];
    logic [NV*VW-1:0] stim_q [$];

    constraint_stream_checker #(.NUM_VARS(NV), .VAR_W(VW), .NUM_CONS(NC), .CNT_W(CNTW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_vars(in_vars),
        .out_valid(out_valid), .out_ready(out_ready), .out_pass(out_pass),
        .out_fail_idx(out_fail_idx), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .pass_cnt(pass_cnt), .hit_vars(hit_vars));

    constraint_stream_checker #(.NUM_VARS(NV6), .VAR_W(VW), .NUM_CONS(NC), .CNT_W(CNTW)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .stop(stop6),
        .cfg_we(cfg_we6), .cfg_idx(cfg_idx6), .cfg_data(cfg_data6),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_vars(in_vars6),
        .out_valid(out_valid6), .out_ready(1'b1), .out_pass(out_pass6),
        .out_fail_idx(out_fail_idx6), .busy(busy6), .done(done6),
        .sample_cnt(sample_cnt6), .pass_cnt(pass_cnt6), .hit_vars(hit_vars6));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Result monitor: records handshakes, counts done pulses, and checks that
    // a stalled result is held unchanged into the next cycle.
    initial begin
        logic       prev_stall;
        logic [4:0] prev_out;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall && {out_valid, out_pass, out_fail_idx} !== {1'b1, prev_out})
                    stall_err++;
                if (out_valid && out_ready) res_q.push_back({out_pass, out_fail_idx});
                if (done) done_cnt++;
            end
            prev_stall = rst_n && out_valid && !out_ready;
            prev_out   = {out_pass, out_fail_idx};
        end
    end

    function automatic logic [CFGW-1:0] mk_cfg(input logic [2:0] op, input logic ui,
                                               input logic [IW-1:0] sa, input logic [IW-1:0] sb,
                                               input logic [VW-1:0] imm);
        return {op, ui, sa, sb, imm};
    endfunction

    function automatic logic [NV*VW-1:0] mk_vars(input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                                                 input logic [VW-1:0] v2);
        logic [NV*VW-1:0] r;
        r = '0;
        r[0 +: VW]    = v0;
        r[VW +: VW]   = v1;
        r[2*VW +: VW] = v2;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [CW-1:0] idx, input logic [CFGW-1:0] data);
        cfg_we = 1'b1; cfg_idx = idx; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        res_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers stim_q in order; a sample leaves the queue only on a handshake edge.
    task automatic feed_all(input int budget);
        logic acc;
        for (int c = 0; c < budget && stim_q.size() > 0; c++) begin
            in_valid = 1'b1;
            in_vars  = stim_q[0];
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) void'(stim_q.pop_front());
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && busy; c++) tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b, required 0 within 100 cycles", busy);
        end
    endtask

    task automatic finish_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle();
    endtask

    task automatic run_batch();
        pulse_start();
        feed_all(200);
        finish_run();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_vec++;
        if ({busy, done, out_valid, in_ready, out_pass, out_fail_idx} !== '0) begin
            n_err++;
            $display("FAIL reset_flags: busy/done/ov/ir/pass/idx=%b, required 0",
                     {busy, done, out_valid, in_ready, out_pass, out_fail_idx});
        end
        n_vec++;
        if (sample_cnt !== '0 || pass_cnt !== '0 || hit_vars !== '0) begin
            n_err++;
            $display("FAIL reset_stats: sample=%0d pass=%0d hit=%h, required all 0",
                     sample_cnt, pass_cnt, hit_vars);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // No slot programmed: every sample passes. Also: start+stop together in IDLE
    // starts the run, and latency is two register stages.
    task automatic test_all_nop();
        res_q.delete();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_wins: busy=%b in_ready=%b, required 1/1", busy, in_ready);
        end
        in_valid = 1'b1;
        in_vars  = mk_vars(32'd11, 32'd12, 32'd13);
        tick();                         // accepting edge: sample now in S1
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: out_valid=%b one edge after accept, required 0", out_valid);
        end
        tick();                         // S2 loaded
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency: out_valid=%b two edges after accept, required 1", out_valid);
        end
        for (int i = 0; i < 3; i++) stim_q.push_back(mk_vars(i, i + 1, 0));
        feed_all(50);
        finish_run();
        n_vec++;
        if (res_q.size() != 4) begin
            n_err++;
            $display("FAIL nop_count: got %0d results, required 4", res_q.size());
        end
        for (int i = 0; i < res_q.size(); i++) begin
            n_vec++;
            if (res_q[i] !== 5'b1_0000) begin
                n_err++;
                $display("FAIL nop_res[%0d]: got %b, required 10000", i, res_q[i]);
            end
        end
        n_vec++;
        if (sample_cnt !== 4 || pass_cnt !== 4) begin
            n_err++;
            $display("FAIL nop_stats: sample=%0d pass=%0d, required 4/4", sample_cnt, pass_cnt);
        end
    endtask

    // Slot3: v0==5 (immediate). Then slot1: v2!=0, lowest failing slot wins.
    task automatic test_fail_index();
        cfg_write(3, mk_cfg(3'd2, 1'b1, 0, 0, 32'd5));
        stim_q.push_back(mk_vars(5, 0, 1));
        stim_q.push_back(mk_vars(7, 0, 1));
        exp_q = '{5'b1_0000, 5'b0_0011};
        run_batch();
        cfg_write(1, mk_cfg(3'd1, 1'b0, 2, 0, 0));
        stim_q.push_back(mk_vars(5, 0, 0));
        stim_q.push_back(mk_vars(7, 0, 0));
        stim_q.push_back(mk_vars(5, 0, 4));
        exp_q = {exp_q, 5'b0_0001, 5'b0_0001, 5'b1_0000};
        begin
            logic [4:0] first [$];
            first = res_q;
            run_batch();
            res_q = {first, res_q};
        end
        n_vec++;
        if (res_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL idx_count: got %0d results, required %0d", res_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
            n_vec++;
            if (res_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL idx_res[%0d]: got pass/idx %b, required %b", i, res_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (sample_cnt !== 3 || pass_cnt !== 1) begin
            n_err++;
            $display("FAIL idx_stats: sample=%0d pass=%0d, required 3/1", sample_cnt, pass_cnt);
        end
    endtask

    // Every op on slot0 with A=v0, B=v1 over five operand pairs.
    task automatic test_ops();
        logic [VW-1:0] pa [5];
        logic [VW-1:0] pb [5];
        logic [4:0]    mask [8];
        pa   = '{32'd3, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5};
        pb   = '{32'd3, 32'd5, 32'd1,         32'd0, 32'd2};
        // bit i = expected pass for pair i
        mask = '{5'b11111, 5'b10111, 5'b01001, 5'b10110,
                 5'b00010, 5'b10011, 5'b00101, 5'b10110};
        cfg_write(1, '0);
        cfg_write(3, '0);
        for (int op = 0; op < 8; op++) begin
            cfg_write(0, mk_cfg(3'(op), 1'b0, 0, 1, 0));
            for (int i = 0; i < 5; i++) stim_q.push_back(mk_vars(pa[i], pb[i], 0));
            run_batch();
            n_vec++;
            if (res_q.size() != 5) begin
                n_err++;
                $display("FAIL op%0d_count: got %0d results, required 5", op, res_q.size());
            end
            for (int i = 0; i < 5 && i < res_q.size(); i++) begin
                n_vec++;
                if (res_q[i] !== {mask[op][i], 4'd0}) begin
                    n_err++;
                    $display("FAIL op%0d_pair%0d: got pass/idx %b, required %b",
                             op, i, res_q[i], {mask[op][i], 4'd0});
                end
            end
        end
        cfg_write(0, '0);
    endtask

    // NUM_VARS=6: slot0 v5!=0 holds, slot1 reads nonexistent v7 as 0 and fails.
    task automatic test_sel_range();
        cfg_we6 = 1'b1; cfg_idx6 = 0; cfg_data6 = mk_cfg(3'd1, 1'b0, 5, 0, 0);
        tick();
        cfg_idx6 = 1; cfg_data6 = mk_cfg(3'd1, 1'b0, 7, 0, 0);
        tick();
        cfg_we6 = 1'b0;
        start6 = 1'b1; tick(); start6 = 1'b0;
        in_valid6 = 1'b1; in_vars6 = '1;
        tick();
        in_valid6 = 1'b0;
        tick();
        n_vec++;
        if ({out_valid6, out_pass6, out_fail_idx6} !== 6'b1_0_0001) begin
            n_err++;
            $display("FAIL sel_range: got valid/pass/idx %b, required 100001",
                     {out_valid6, out_pass6, out_fail_idx6});
        end
        stop6 = 1'b1; tick(); stop6 = 1'b0;
    endtask

    // 100 samples, slot2 v0<50, random output backpressure.
    task automatic test_backpressure();
        int stall0;
        stall0 = stall_err;
        cfg_write(2, mk_cfg(3'd4, 1'b1, 0, 0, 32'd50));
        exp_q.delete();
        for (int i = 0; i < 100; i++) begin
            stim_q.push_back(mk_vars(i, 32'h5A00 + i, 0));
            exp_q.push_back(i < 50 ? 5'b1_0000 : 5'b0_0010);
        end
        pulse_start();
        fork
            feed_all(2000);
            begin
                for (int c = 0; c < 3000 && res_q.size() < 100; c++) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        finish_run();
        n_vec++;
        if (res_q.size() != 100) begin
            n_err++;
            $display("FAIL bp_count: got %0d results, required 100", res_q.size());
        end
        for (int i = 0; i < 100 && i < res_q.size(); i++) begin
            n_vec++;
            if (res_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL bp_res[%0d]: got pass/idx %b, required %b", i, res_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (stall_err != stall0) begin
            n_err++;
            $display("FAIL bp_hold: %0d stalled cycles changed output, required 0", stall_err - stall0);
        end
        n_vec++;
        if (sample_cnt !== 100 || pass_cnt !== 50) begin
            n_err++;
            $display("FAIL bp_stats: sample=%0d pass=%0d, required 100/50", sample_cnt, pass_cnt);
        end
    endtask

    // Stop with two in flight; cfg write during RUN must be ignored.
    task automatic test_stop_drain();
        int d0;
        cfg_write(2, '0);
        out_ready = 1'b1;
        pulse_start();
        d0 = done_cnt;
        in_valid = 1'b1;
        in_vars  = mk_vars(0, 1, 2);
        cfg_we = 1'b1; cfg_idx = 0; cfg_data = mk_cfg(3'd1, 1'b0, 0, 0, 0);  // v0!=0 would fail both
        tick();
        cfg_we  = 1'b0;
        in_vars = mk_vars(0, 3, 4);
        tick();
        in_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        in_valid = 1'b1;
        in_vars  = mk_vars(0, 5, 6);
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL drain_ready: in_ready=%b busy=%b, required 0/1", in_ready, busy);
        end
        wait_idle();
        in_valid = 1'b0;
        n_vec++;
        if (res_q.size() != 2 || res_q[0] !== 5'b1_0000 || res_q[1] !== 5'b1_0000) begin
            n_err++;
            $display("FAIL drain_res: got %0d results, first two %b %b, required 2 x 10000",
                     res_q.size(), res_q[0], res_q[1]);
        end
        n_vec++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL done_pulse: done high %0d cycles, required 1", done_cnt - d0);
        end
        n_vec++;
        if (sample_cnt !== 2 || pass_cnt !== 2) begin
            n_err++;
            $display("FAIL drain_stats: sample=%0d pass=%0d, required 2/2", sample_cnt, pass_cnt);
        end
    endtask

    // Slot0 v0==3: only the 3rd of 10 samples passes.
    task automatic test_hit_stop();
        logic [NV*VW-1:0] third;
        cfg_write(0, mk_cfg(3'd2, 1'b1, 0, 0, 32'd3));
        for (int i = 0; i < 10; i++) stim_q.push_back(mk_vars(i + 1, 32'hA0 + i, 0));
        third = mk_vars(3, 32'hA2, 0);
        out_ready = 1'b1;
        pulse_start();
`ifdef CSC_HIT_STOP_EN
        feed_all(40);
        stim_q.delete();
        wait_idle();
        n_vec++;
        if (hit_vars !== third) begin
            n_err++;
            $display("FAIL hit_vars: got %h, required %h", hit_vars, third);
        end
        n_vec++;
        if (sample_cnt > 5 || sample_cnt < 3 || pass_cnt !== 1) begin
            n_err++;
            $display("FAIL hit_stats: sample=%0d pass=%0d, required 3..5/1", sample_cnt, pass_cnt);
        end
        n_vec++;
        if (res_q.size() < 3 || res_q[2] !== 5'b1_0000) begin
            n_err++;
            $display("FAIL hit_res: %0d results, third %b, required third 10000", res_q.size(), res_q[2]);
        end
        pulse_start();
        n_vec++;
        if (hit_vars !== '0) begin
            n_err++;
            $display("FAIL hit_clear: got %h after start, required 0", hit_vars);
        end
        finish_run();
`else
        feed_all(100);
        finish_run();
        n_vec++;
        if (hit_vars !== '0) begin
            n_err++;
            $display("FAIL hit_vars: got %h, required 0", hit_vars);
        end
        n_vec++;
        if (res_q.size() != 10 || res_q[2] !== 5'b1_0000 || res_q[3] !== 5'b0_0000) begin
            n_err++;
            $display("FAIL hit_res: %0d results, third %b fourth %b, required 10, 10000, 00000",
                     res_q.size(), res_q[2], res_q[3]);
        end
        n_vec++;
        if (sample_cnt !== 10 || pass_cnt !== 1) begin
            n_err++;
            $display("FAIL hit_stats: sample=%0d pass=%0d, required 10/1", sample_cnt, pass_cnt);
        end
`endif
    endtask

    // Async reset mid-run clears everything, including the slot table.
    task automatic test_reset_mid();
        cfg_write(0, mk_cfg(3'd1, 1'b0, 0, 0, 0));   // v0!=0
        pulse_start();
        in_valid = 1'b1;
        in_vars  = mk_vars(0, 7, 7);
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sample_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_mid: out_valid=%b busy=%b sample=%0d, required 0/0/0",
                     out_valid, busy, sample_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        stim_q.push_back(mk_vars(0, 7, 7));
        run_batch();
        n_vec++;
        if (res_q.size() != 1 || res_q[0] !== 5'b1_0000) begin
            n_err++;
            $display("FAIL reset_table: %0d results, first %b, required 1 x 10000",
                     res_q.size(), res_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_all_nop();
        test_fail_index();
        test_ops();
        test_sel_range();
        test_backpressure();
        test_stop_drain();
        test_hit_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
